// File: rtl/ds_bitstream_packer_if.sv
// ds_bitstream_packer_if
// UART-side flow-control bundle: the packer presents the FIFO head byte with
// data_rdy, and the consumer pops it with a rising edge on data_read.
interface ds_bitstream_packer_if;
    logic [7:0] byte_out;
    logic       data_rdy;
    logic       data_read;

    modport master (output byte_out, output data_rdy, input data_read);
    modport slave  (input byte_out, input data_rdy, output data_read);
endinterface

// File: rtl/ds_bitstream_packer.sv
// ds_bitstream_packer
// Samples the 1-bit delta-sigma stream once every SAMPLE_DIV clocks, packs
// 8 samples LSB-first into a byte and queues bytes in a 2**DEPTH_LOG2 FIFO
// whose head is offered to the UART transmitter.
// Optional macro PACKER_INPUT_SYNC_EN: routes adc_in through a 2-flop
// synchronizer first (2 extra cycles of input latency).
// DEPTH_LOG2 must be at least 1.
module ds_bitstream_packer #(
    parameter int SAMPLE_DIV = 50,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adc_in,
    ds_bitstream_packer_if.master   bus,
    output logic                    overflow,
    output logic [DEPTH_LOG2:0]     fill_level,
    output logic                    sample_tick
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);

    logic [TICK_W-1:0]   tickCnt;
    logic [2:0]          bitCnt;
    logic [7:0]          shiftReg;
    logic [7:0]          fifoMem [DEPTH];
    logic [DEPTH_LOG2:0] wrPtr;
    logic [DEPTH_LOG2:0] rdPtr;
    logic                dataReadQ;
    logic                adcSample;

    logic                tickNow;
    logic                byteDone;
    logic                fifoFull;
    logic                popReq;
    logic                pushAccept;
    logic                overflowHit;
    logic [7:0]          newByte;
    logic [7:0]          headNext;
    logic [DEPTH_LOG2:0] rdPtrNext;
    logic [DEPTH_LOG2:0] wrPtrNext;

`ifdef PACKER_INPUT_SYNC_EN
    logic adcSync1;
    logic adcSync2;

    // Two-flop synchronizer so an asynchronous modulator output can be sampled safely
    always_ff @(posedge clk) begin
        if (rst) begin
            adcSync1 <= 1'b0;
            adcSync2 <= 1'b0;
        end else begin
            adcSync1 <= adc_in;
            adcSync2 <= adcSync1;
        end
    end

    assign adcSample = adcSync2;
`else
    assign adcSample = adc_in;
`endif

    assign tickNow     = (tickCnt == TICK_LAST);
    assign sample_tick = tickNow;
    assign fill_level  = wrPtr - rdPtr;
    assign fifoFull    = fill_level[DEPTH_LOG2];

    // Decide this cycle's push/pop and work out where the head will be afterwards
    always_comb begin
        newByte     = shiftReg;
        newByte[7]  = adcSample;
        byteDone    = tickNow && (bitCnt == 3'd7);
        popReq      = bus.data_read && !dataReadQ && (fill_level != '0);
        pushAccept  = byteDone && (!fifoFull || popReq);
        overflowHit = byteDone && fifoFull && !popReq;
        rdPtrNext   = popReq ? rdPtr + 1'b1 : rdPtr;
        wrPtrNext   = pushAccept ? wrPtr + 1'b1 : wrPtr;
        headNext    = (rdPtrNext == wrPtr) ? newByte
                                           : fifoMem[rdPtrNext[DEPTH_LOG2-1:0]];
    end

    // Free-running sample divider, wrapping after SAMPLE_DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            tickCnt <= '0;
        end else if (tickNow) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + 1'b1;
        end
    end

    // Shift samples in LSB-first so the UART puts them on the wire in sample order
    always_ff @(posedge clk) begin
        if (rst) begin
            bitCnt   <= '0;
            shiftReg <= '0;
        end else if (tickNow) begin
            shiftReg[bitCnt] <= adcSample;
            bitCnt           <= bitCnt + 3'd1;
        end
    end

    // Byte storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (pushAccept) begin
            fifoMem[wrPtr[DEPTH_LOG2-1:0]] <= newByte;
        end
    end

    // Pointers, handshake edge detect, sticky overflow and the registered head byte
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            dataReadQ    <= 1'b1;
            overflow     <= 1'b0;
            bus.byte_out <= '0;
            bus.data_rdy <= 1'b0;
        end else begin
            wrPtr        <= wrPtrNext;
            rdPtr        <= rdPtrNext;
            dataReadQ    <= bus.data_read;
            bus.data_rdy <= (wrPtrNext != rdPtrNext);
            if (overflowHit) begin
                overflow <= 1'b1;
            end
            if (wrPtrNext != rdPtrNext) begin
                bus.byte_out <= headNext;
            end
        end
    end

endmodule

// File: tb/tb_ds_bitstream_packer.sv
// tb_ds_bitstream_packer
// Directed scenarios plus a randomized run, all checked against a queue-based
// model of the packer kept in this file.
module tb_ds_bitstream_packer;

    localparam int SAMPLE_DIV = 4;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 4;
`ifdef PACKER_INPUT_SYNC_EN
    localparam int LEAD = 2;
`else
    localparam int LEAD = 0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                adc_in = 1'b0;
    logic                overflow;
    logic [DEPTH_LOG2:0] fill_level;
    logic                sample_tick;

    ds_bitstream_packer_if bus();

    ds_bitstream_packer #(.SAMPLE_DIV(SAMPLE_DIV), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk(clk),
        .rst(rst),
        .adc_in(adc_in),
        .bus(bus),
        .overflow(overflow),
        .fill_level(fill_level),
        .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] mLast;
    bit         mOvf;
    int         mBits;
    logic [7:0] mAcc;
    bit         mPrevRead;
    int         mCyc;
    bit         mS1, mS2;

    // Behavioural model: counts clocks since reset, collects 8 samples into a byte, queues bytes
    always @(posedge clk) begin : model
        bit tick, pop, push, fullBefore, smp;
        logic [7:0] nb;
        if (rst) begin
            mq.delete();
            mLast = 8'h00; mOvf = 0; mBits = 0; mAcc = 8'h00;
            mPrevRead = 1; mCyc = 0; mS1 = 0; mS2 = 0;
        end else begin
`ifdef PACKER_INPUT_SYNC_EN
            smp = mS2; mS2 = mS1; mS1 = adc_in;
`else
            smp = adc_in;
`endif
            tick = (mCyc % SAMPLE_DIV) == SAMPLE_DIV - 1;
            pop = bus.data_read && !mPrevRead && (mq.size() > 0);
            fullBefore = mq.size() >= DEPTH;
            push = 0;
            nb = 8'h00;
            if (tick) begin
                if (smp) mAcc = mAcc + 8'(1 << mBits);
                mBits++;
                if (mBits == 8) begin
                    push = 1; nb = mAcc; mAcc = 8'h00; mBits = 0;
                end
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (!fullBefore || pop) mq.push_back(nb);
                else mOvf = 1;
            end
            if (mq.size() > 0) mLast = mq[0];
            mPrevRead = bus.data_read;
            mCyc++;
        end
    end

    // Assert reset for n cycles starting from a negedge
    task automatic doReset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one sample so that it is captured by the next sample tick
    task automatic sendBit(input logic b);
        int guard = 0;
        while (((mCyc + LEAD) % SAMPLE_DIV) != SAMPLE_DIV - 1 && guard < 2 * SAMPLE_DIV) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 2 * SAMPLE_DIV) begin
            errors++;
            $display("[TB] FAIL tick_wait: waited %0d cycles, required < %0d", guard, 2 * SAMPLE_DIV);
        end
        adc_in = b;
        repeat (LEAD + 1) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) sendBit(v[i]);
    endtask

    task automatic test_reset();
        bus.data_read = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adc_in = ~adc_in;
            @(negedge clk);
        end
        checks += 5;
        if (bus.byte_out !== 8'h00) begin errors++; $display("[TB] FAIL rst_byte_out: got %h need 00", bus.byte_out); end
        if (bus.data_rdy !== 1'b0) begin errors++; $display("[TB] FAIL rst_data_rdy: got %b need 0", bus.data_rdy); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_overflow: got %b need 0", overflow); end
        if (fill_level !== 3'd0) begin errors++; $display("[TB] FAIL rst_fill: got %0d need 0", fill_level); end
        if (sample_tick !== 1'b0) begin errors++; $display("[TB] FAIL rst_tick: got %b need 0", sample_tick); end
        rst = 1'b0;
        // Tick strobe first seen after SAMPLE_DIV-1 edges, so it is captured on edge SAMPLE_DIV
        for (int k = 0; k < SAMPLE_DIV; k++) begin
            checks += 2;
            if (sample_tick !== (k == SAMPLE_DIV - 1)) begin
                errors++;
                $display("[TB] FAIL first_tick: edge %0d got %b need %b", k, sample_tick, (k == SAMPLE_DIV - 1));
            end
            if (bus.data_rdy !== 1'b0 || fill_level !== 3'd0) begin
                errors++;
                $display("[TB] FAIL rst_no_pop: edge %0d rdy %b fill %0d need 0/0", k, bus.data_rdy, fill_level);
            end
            if (k < SAMPLE_DIV - 1) @(negedge clk);
        end
    endtask

    task automatic test_packing();
        logic [7:0] pattern;
        pattern = 8'b1000_1101;
        bus.data_read = 1'b0;
        doReset(1);
        for (int i = 0; i < 7; i++) sendBit(pattern[i]);
        checks++;
        if (bus.data_rdy !== 1'b0) begin errors++; $display("[TB] FAIL pack_early: rdy %b need 0 after 7 ticks", bus.data_rdy); end
        sendBit(pattern[7]);
        checks += 4;
        if (bus.byte_out !== 8'h8D) begin errors++; $display("[TB] FAIL pack_byte: got %h need 8d", bus.byte_out); end
        if (bus.data_rdy !== 1'b1) begin errors++; $display("[TB] FAIL pack_rdy: got %b need 1", bus.data_rdy); end
        if (fill_level !== 3'd1) begin errors++; $display("[TB] FAIL pack_fill: got %0d need 1", fill_level); end
        if (bus.byte_out !== mLast) begin errors++; $display("[TB] FAIL pack_model: got %h model %h", bus.byte_out, mLast); end
    endtask

    task automatic test_handshake();
        bus.data_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (fill_level !== 3'd0 || bus.data_rdy !== 1'b0 || bus.byte_out !== 8'h8D) begin
                errors++;
                $display("[TB] FAIL hold_pop: cycle %0d fill %0d rdy %b byte %h need 0/0/8d", i, fill_level, bus.data_rdy, bus.byte_out);
            end
        end
        bus.data_read = 1'b0;
        @(negedge clk);
        bus.data_read = 1'b1;
        repeat (2) @(negedge clk);
        checks += 3;
        if (fill_level !== 3'd0) begin errors++; $display("[TB] FAIL empty_pop_fill: got %0d need 0", fill_level); end
        if (bus.data_rdy !== 1'b0) begin errors++; $display("[TB] FAIL empty_pop_rdy: got %b need 0", bus.data_rdy); end
        if (bus.byte_out !== 8'h8D) begin errors++; $display("[TB] FAIL empty_pop_byte: got %h need 8d", bus.byte_out); end
        bus.data_read = 1'b0;
    endtask

    task automatic popExpect(input logic [7:0] exp, input string tag);
        checks++;
        if (bus.byte_out !== exp || bus.data_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: byte %h rdy %b need %h/1", tag, bus.byte_out, bus.data_rdy, exp);
        end
        bus.data_read = 1'b1;
        @(negedge clk);
        bus.data_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        bus.data_read = 1'b0;
        doReset(1);
        for (int b = 1; b <= 4; b++) sendByte(8'(b));
        checks += 3;
        if (fill_level !== 3'd4) begin errors++; $display("[TB] FAIL full_fill: got %0d need 4", fill_level); end
        if (bus.byte_out !== 8'h01) begin errors++; $display("[TB] FAIL full_head: got %h need 01", bus.byte_out); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_ovf: got %b need 0", overflow); end
        sendByte(8'h05);
        checks += 3;
        if (fill_level !== 3'd4) begin errors++; $display("[TB] FAIL ovf_fill: got %0d need 4", fill_level); end
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b need 1", overflow); end
        if (bus.byte_out !== 8'h01) begin errors++; $display("[TB] FAIL ovf_head: got %h need 01", bus.byte_out); end
        for (int b = 1; b <= 4; b++) popExpect(8'(b), "ovf_drain");
        checks += 3;
        if (bus.data_rdy !== 1'b0 || fill_level !== 3'd0) begin errors++; $display("[TB] FAIL drain_empty: rdy %b fill %0d need 0/0", bus.data_rdy, fill_level); end
        if (bus.byte_out !== 8'h04) begin errors++; $display("[TB] FAIL drain_hold: got %h need 04", bus.byte_out); end
        if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b need 1", overflow); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] v;
        int guard = 0;
        v = 8'h5C;
        bus.data_read = 1'b0;
        doReset(1);
        for (int b = 0; b < 4; b++) sendByte(8'hA1 + 8'(b));
        for (int i = 0; i < 7; i++) sendBit(v[i]);
        while (((mCyc + LEAD) % SAMPLE_DIV) != SAMPLE_DIV - 1 && guard < 2 * SAMPLE_DIV) begin
            @(negedge clk);
            guard++;
        end
        adc_in = v[7];
        repeat (LEAD) @(negedge clk);
        bus.data_read = 1'b1;
        @(negedge clk);
        bus.data_read = 1'b0;
        checks += 4;
        if (fill_level !== 3'd4) begin errors++; $display("[TB] FAIL sim_fill: got %0d need 4", fill_level); end
        if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL sim_ovf: got %b need 0", overflow); end
        if (bus.byte_out !== 8'hA2) begin errors++; $display("[TB] FAIL sim_head: got %h need a2", bus.byte_out); end
        if (guard >= 2 * SAMPLE_DIV) begin errors++; $display("[TB] FAIL sim_tick_wait: waited %0d cycles", guard); end
        @(negedge clk);
        popExpect(8'hA2, "sim_drain");
        popExpect(8'hA3, "sim_drain");
        popExpect(8'hA4, "sim_drain");
        popExpect(8'h5C, "sim_last");
    endtask

    task automatic test_reset_midbyte();
        bus.data_read = 1'b0;
        doReset(1);
        for (int i = 0; i < 5; i++) sendBit(1'b0);
        doReset(1);
        for (int i = 0; i < 7; i++) sendBit(1'b1);
        checks++;
        if (bus.data_rdy !== 1'b0) begin errors++; $display("[TB] FAIL mid_early: rdy %b need 0 after 7 ticks", bus.data_rdy); end
        sendBit(1'b1);
        checks += 2;
        if (bus.byte_out !== 8'hFF) begin errors++; $display("[TB] FAIL mid_byte: got %h need ff", bus.byte_out); end
        if (fill_level !== 3'd1) begin errors++; $display("[TB] FAIL mid_fill: got %0d need 1", fill_level); end
    endtask

    task automatic test_random();
        int toggleOdds;
        bus.data_read = 1'b0;
        doReset(1);
        for (int c = 0; c < 800; c++) begin
            checks += 5;
            if (bus.byte_out !== mLast) begin errors++; $display("[TB] FAIL rnd_byte: cyc %0d got %h model %h", c, bus.byte_out, mLast); end
            if (bus.data_rdy !== (mq.size() > 0)) begin errors++; $display("[TB] FAIL rnd_rdy: cyc %0d got %b model %b", c, bus.data_rdy, (mq.size() > 0)); end
            if (fill_level !== 3'(mq.size())) begin errors++; $display("[TB] FAIL rnd_fill: cyc %0d got %0d model %0d", c, fill_level, mq.size()); end
            if (overflow !== mOvf) begin errors++; $display("[TB] FAIL rnd_ovf: cyc %0d got %b model %b", c, overflow, mOvf); end
            if (sample_tick !== ((mCyc % SAMPLE_DIV) == SAMPLE_DIV - 1)) begin errors++; $display("[TB] FAIL rnd_tick: cyc %0d got %b", c, sample_tick); end
            // Slow reader first to fill and overflow, then a fast reader to drain
            toggleOdds = (c < 400) ? 60 : 3;
            adc_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, toggleOdds - 1) == 0) bus.data_read = ~bus.data_read;
            @(negedge clk);
        end
        bus.data_read = 1'b0;
    endtask

    // Hard stop in case something stalls the sequence
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Scenario sequence
    initial begin
        bus.data_read = 1'b1;
        test_reset();
        test_packing();
        test_handshake();
        test_overflow();
        test_simultaneous();
        test_reset_midbyte();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
